// File: rtl/sdu_pkg.sv
// Shared types and default sizing for the SDU frame sequencer.
// Defaults match the FIR prime/flush lengths and the FFT frame size.
package sdu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_DATA,
    ST_FLUSH,
    ST_WAIT_DONE,
    ST_UNLOAD,
    ST_DRAIN
  } state_t;

  localparam int DEF_PRIME_LEN    = 106;
  localparam int DEF_FRAME_LEN    = 128;
  localparam int DEF_FLUSH_LEN    = 43;
  localparam int DEF_DONE_TIMEOUT = 4096;
  localparam int SAMPLE_W         = 16;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Wide enough to hold the largest phase length without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    return $clog2(max4(a, b, c, d) + 1);
  endfunction

endpackage

// File: rtl/sdu_frame_sequencer_if.sv
// Upstream sample stream: signed I/Q sample with valid/ready handshake.
interface sdu_frame_sequencer_if;
  import sdu_pkg::*;

  logic signed [SAMPLE_W-1:0] s_re;
  logic signed [SAMPLE_W-1:0] s_im;
  logic                       s_valid;
  logic                       s_ready;

  modport master (output s_re, output s_im, output s_valid, input s_ready);
  modport slave  (input s_re, input s_im, input s_valid, output s_ready);

endinterface

// File: rtl/sdu_cycle_counter.sv
// Phase counter: cleared by load, advanced by en; tc flags count == last.
module sdu_cycle_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign tc = (count_reg == last);

endmodule

// File: rtl/sdu_frame_sequencer.sv
// Drives one frame through the FIR/FFT chain: prime zeros, data, flush zeros,
// then waits for the FFT, unloads it and counts the output words.
module sdu_frame_sequencer
  import sdu_pkg::*;
#(
  parameter int PRIME_LEN    = DEF_PRIME_LEN,
  parameter int FRAME_LEN    = DEF_FRAME_LEN,
  parameter int FLUSH_LEN    = DEF_FLUSH_LEN,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  sdu_frame_sequencer_if.slave       s_if,
  output logic signed [SAMPLE_W-1:0] din_re,
  output logic signed [SAMPLE_W-1:0] din_im,
  output logic                       fir_filter_nd,
  input  logic                       fft_done,
  output logic                       fft_unload,
  input  logic                       fft_dv,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       timeout_err
);

  localparam int CNT_W = cnt_width(PRIME_LEN, FRAME_LEN, FLUSH_LEN, DONE_TIMEOUT);
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_LEN - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(DONE_TIMEOUT - 1);

  state_t                     state_reg;
  logic signed [SAMPLE_W-1:0] din_re_reg;
  logic signed [SAMPLE_W-1:0] din_im_reg;
  logic                       nd_reg;
  logic                       unload_reg;
  logic                       busy_reg;
  logic                       frame_done_reg;
  logic                       timeout_err_reg;

  logic             accept;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CNT_W-1:0] cnt_last;

  assign s_if.s_ready = (state_reg == ST_DATA);
  assign accept       = s_if.s_ready && s_if.s_valid;

  always_comb begin
    cnt_last = PRIME_LAST;
    case (state_reg)
      ST_DATA, ST_DRAIN: cnt_last = FRAME_LAST;
      ST_FLUSH:          cnt_last = FLUSH_LAST;
      ST_WAIT_DONE:      cnt_last = TMO_LAST;
      default:           cnt_last = PRIME_LAST;
    endcase
  end

  // Counter restarts from zero on every phase change, so each phase sees a fresh count.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_reg)
      ST_IDLE:      cnt_load = 1'b1;
      ST_PRIME:     begin cnt_en = 1'b1;   cnt_load = cnt_tc;             end
      ST_DATA:      begin cnt_en = accept; cnt_load = accept && cnt_tc;   end
      ST_FLUSH:     begin cnt_en = 1'b1;   cnt_load = cnt_tc;             end
      ST_WAIT_DONE: begin cnt_en = 1'b1;   cnt_load = fft_done || cnt_tc; end
      ST_UNLOAD:    cnt_load = 1'b1;
      ST_DRAIN:     begin cnt_en = fft_dv; cnt_load = fft_dv && cnt_tc;   end
      default:      cnt_load = 1'b1;
    endcase
  end

  sdu_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .last  (cnt_last),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_IDLE;
      din_re_reg      <= '0;
      din_im_reg      <= '0;
      nd_reg          <= 1'b0;
      unload_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      nd_reg         <= 1'b0;
      unload_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg       <= ST_PRIME;
            busy_reg        <= 1'b1;
            timeout_err_reg <= 1'b0;
          end
        end
        ST_PRIME: begin
          nd_reg     <= 1'b1;
          din_re_reg <= '0;
          din_im_reg <= '0;
          if (cnt_tc) state_reg <= ST_DATA;
        end
        ST_DATA: begin
          if (accept) begin
            nd_reg     <= 1'b1;
            din_re_reg <= s_if.s_re;
            din_im_reg <= s_if.s_im;
            if (cnt_tc) state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          nd_reg     <= 1'b1;
          din_re_reg <= '0;
          din_im_reg <= '0;
          if (cnt_tc) state_reg <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (fft_done) begin
            state_reg  <= ST_UNLOAD;
            unload_reg <= 1'b1;
          end else if (cnt_tc) begin
            state_reg       <= ST_IDLE;
            busy_reg        <= 1'b0;
            timeout_err_reg <= 1'b1;
          end
        end
        ST_UNLOAD: state_reg <= ST_DRAIN;
        ST_DRAIN: begin
          if (fft_dv && cnt_tc) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign din_re        = din_re_reg;
  assign din_im        = din_im_reg;
  assign fir_filter_nd = nd_reg;
  assign fft_unload    = unload_reg;
  assign busy          = busy_reg;
  assign frame_done    = frame_done_reg;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_sdu_frame_sequencer.sv
// Frame-level bench: scenario table plus reset sequences, checked against a
// timeline model built from the phase lengths and the handshake history.
module tb_sdu_frame_sequencer;
  import sdu_pkg::*;

  localparam int PL    = DEF_PRIME_LEN;
  localparam int FL    = DEF_FRAME_LEN;
  localparam int XL    = DEF_FLUSH_LEN;
  localparam int TO    = DEF_DONE_TIMEOUT;
  localparam int TOTAL = PL + FL + XL;

  typedef struct {
    int vmode;      // 0: valid always high with impulse data, 1: random valid/data
    int dvmode;     // 0: dv continuous, 1: alternating, 2: random
    bit noise;      // stray start/fft_done/fft_dv outside their phases
    int done_wait;  // WAIT_DONE cycles before fft_done, -1 = never
    int e_nd;
    int e_acc;
    int e_fd;
    int e_unload;
    bit e_terr;
  } vec_t;

  logic clk;
  logic reset;
  logic start;
  logic fft_done;
  logic fft_dv;
  logic signed [15:0] din_re;
  logic signed [15:0] din_im;
  logic fir_filter_nd;
  logic fft_unload;
  logic busy;
  logic frame_done;
  logic timeout_err;

  sdu_frame_sequencer_if s_if ();

  sdu_frame_sequencer #(
    .PRIME_LEN    (PL),
    .FRAME_LEN    (FL),
    .FLUSH_LEN    (XL),
    .DONE_TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .s_if          (s_if),
    .din_re        (din_re),
    .din_im        (din_im),
    .fir_filter_nd (fir_filter_nd),
    .fft_done      (fft_done),
    .fft_unload    (fft_unload),
    .fft_dv        (fft_dv),
    .busy          (busy),
    .frame_done    (frame_done),
    .timeout_err   (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int nd_cnt, acc_cnt, unload_cnt, fd_cnt;
  int first_nd, last_nd, first_ready, unload_cyc, fd_cyc;
  logic [31:0] nd_q[$];
  logic [31:0] acc_q[$];

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clr_frame();
    nd_cnt = 0; acc_cnt = 0; unload_cnt = 0; fd_cnt = 0;
    first_nd = -1; last_nd = -1; first_ready = -1; unload_cyc = -1; fd_cyc = -1;
    nd_q.delete();
    acc_q.delete();
  endtask

  // Inputs are already set; record the handshake, cross the edge, observe outputs.
  task automatic cycle();
    if (s_if.s_ready && first_ready < 0) first_ready = cyc;
    if (s_if.s_valid && s_if.s_ready) begin
      acc_cnt++;
      acc_q.push_back({s_if.s_re, s_if.s_im});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fir_filter_nd) begin
      if (first_nd < 0) first_nd = cyc;
      last_nd = cyc;
      nd_cnt++;
      nd_q.push_back({din_re, din_im});
    end
    if (fft_unload) begin unload_cnt++; unload_cyc = cyc; end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
  endtask

  task automatic run_frame(input int vmode, input int dvmode, input bit noise, input int done_wait);
    int start_cyc, wait_cnt, done_cyc, fd_exp, to_exp, dv_cnt, seq_err;
    bit done_sent, drain_arm, in_drain, dv_tgl, fin;
    clr_frame();
    s_if.s_valid = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    start_cyc = cyc;
    check("start_busy", busy, 1);
    check("start_terr_clr", timeout_err, 0);
    wait_cnt = 0; done_sent = 0; done_cyc = -1; fd_exp = -1; to_exp = -1;
    dv_cnt = 0; drain_arm = 0; in_drain = 0; dv_tgl = 0; fin = 0;
    for (int b = 0; b < 12000 && !fin; b++) begin
      s_if.s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      s_if.s_re    = (vmode == 0) ? ((acc_cnt == 0) ? 16'sd32 : 16'sd0) : 16'($urandom);
      s_if.s_im    = (vmode == 0) ? 16'sd0 : 16'($urandom);
      fft_done = noise && (nd_cnt < PL + FL) && ($urandom_range(0, 7) == 0);
      fft_dv   = 1'b0;
      if (noise && nd_cnt >= PL + FL && nd_cnt < TOTAL) fft_dv = 1'($urandom_range(0, 1));
      if (nd_cnt == TOTAL && !done_sent && to_exp < 0) begin
        if (done_wait < 0) begin
          to_exp = last_nd + TO;
        end else begin
          if (wait_cnt == done_wait) begin
            fft_done  = 1'b1;
            done_sent = 1'b1;
            done_cyc  = cyc + 1;
          end
          wait_cnt++;
        end
      end
      if (in_drain && fd_exp < 0) begin
        case (dvmode)
          0: fft_dv = 1'b1;
          1: begin fft_dv = dv_tgl; dv_tgl = ~dv_tgl; end
          default: fft_dv = 1'($urandom_range(0, 1));
        endcase
        if (fft_dv) begin
          dv_cnt++;
          if (dv_cnt == FL) fd_exp = cyc + 1;
        end
      end else if (drain_arm) begin
        // This cycle is the unload cycle itself: dv here must not count.
        fft_dv    = 1'b1;
        drain_arm = 1'b0;
        in_drain  = 1'b1;
      end
      start = noise && fd_exp < 0 && to_exp < 0 && ($urandom_range(0, 3) == 0);
      cycle();
      if (fft_unload && !in_drain) drain_arm = 1'b1;
      if (fd_cnt > 0 && fd_exp >= 0 && cyc < fd_exp) check("fd_early", fd_cyc, fd_exp);
      if (to_exp >= 0 && cyc == to_exp - 1) check("pre_timeout_err", timeout_err, 0);
      if (fd_exp >= 0 && cyc == fd_exp) fin = 1;
      if (to_exp >= 0 && cyc == to_exp) fin = 1;
    end
    start = 1'b0; fft_dv = 1'b0; fft_done = 1'b0; s_if.s_valid = 1'b0;
    check("frame_bounded", fin, 1);
    check("first_nd_cycle", first_nd, start_cyc + 1);
    check("first_ready_cycle", first_ready, start_cyc + PL);
    if (vmode == 0) check("nd_contiguous", last_nd - first_nd + 1, nd_cnt);
    seq_err = 0;
    for (int i = 0; i < nd_q.size(); i++) begin
      logic [31:0] e;
      if (i < PL || i >= PL + acc_q.size()) e = 32'd0;
      else e = acc_q[i - PL];
      if (nd_q[i] !== e) seq_err++;
    end
    check("din_sequence_errs", seq_err, 0);
    if (done_wait >= 0) begin
      check("unload_cycle", unload_cyc, done_cyc);
      check("frame_done_cycle", fd_cyc, fd_exp);
    end else begin
      check("timeout_busy", busy, 0);
    end
    check("end_busy", busy, 0);
    cycle();
    check("frame_done_single", frame_done, 0);
    check("idle_nd", fir_filter_nd, 0);
  endtask

  initial begin
    vecs[0] = '{0, 0, 1'b0, 3,  TOTAL, FL, 1, 1, 1'b0};
    vecs[1] = '{1, 2, 1'b0, 0,  TOTAL, FL, 1, 1, 1'b0};
    vecs[2] = '{0, 0, 1'b0, -1, TOTAL, FL, 0, 0, 1'b1};
    vecs[3] = '{1, 0, 1'b1, 10, TOTAL, FL, 1, 1, 1'b0};
    vecs[4] = '{0, 1, 1'b0, 1,  TOTAL, FL, 1, 1, 1'b0};
    vecs[5] = '{1, 2, 1'b1, 20, TOTAL, FL, 1, 1, 1'b0};

    reset = 1'b0; start = 1'b1; fft_done = 1'b0; fft_dv = 1'b0;
    s_if.s_valid = 1'b0; s_if.s_re = '0; s_if.s_im = '0;
    clr_frame();
    for (int i = 0; i < 3; i++) cycle();
    check("rst_busy", busy, 0);
    check("rst_nd", fir_filter_nd, 0);
    check("rst_din", {din_re, din_im}, 0);
    check("rst_unload_fd_terr", {fft_unload, frame_done, timeout_err}, 0);
    check("rst_ready", s_if.s_ready, 0);
    start = 1'b0;
    #3 reset = 1'b1;
    cycle();
    check("post_rst_idle", busy, 0);

    // Abort in the middle of DATA, then confirm silence until a new start.
    clr_frame();
    start = 1'b1; cycle(); start = 1'b0;
    for (int b = 0; b < 2000 && acc_cnt < 60; b++) begin
      s_if.s_valid = 1'b1;
      s_if.s_re = 16'($urandom);
      s_if.s_im = 16'($urandom);
      cycle();
    end
    check("reach_sample_60", acc_cnt, 60);
    #2 reset = 1'b0;
    #1;
    check("abort_nd", fir_filter_nd, 0);
    check("abort_busy", busy, 0);
    check("abort_din", {din_re, din_im}, 0);
    check("abort_ready", s_if.s_ready, 0);
    start = 1'b1;
    cycle(); cycle();
    start = 1'b0;
    #2 reset = 1'b1;
    clr_frame();
    for (int i = 0; i < 5; i++) cycle();
    check("abort_quiet_nd", nd_cnt, 0);
    check("abort_quiet_busy", busy, 0);
    run_frame(0, 0, 1'b0, 2);
    check("restart_nd_total", nd_cnt, TOTAL);
    $display("frame after abort: nd=%0d acc=%0d fd=%0d", nd_cnt, acc_cnt, fd_cnt);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].vmode, vecs[i].dvmode, vecs[i].noise, vecs[i].done_wait);
      check("nd_total", nd_cnt, vecs[i].e_nd);
      check("accepted", acc_cnt, vecs[i].e_acc);
      check("frame_done_count", fd_cnt, vecs[i].e_fd);
      check("unload_count", unload_cnt, vecs[i].e_unload);
      check("timeout_err", timeout_err, vecs[i].e_terr);
      $display("frame %0d: vmode=%0d dvmode=%0d noise=%0d nd=%0d acc=%0d unload=%0d fd=%0d terr=%0d",
               i, vecs[i].vmode, vecs[i].dvmode, vecs[i].noise, nd_cnt, acc_cnt,
               unload_cnt, fd_cnt, timeout_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
